// File: rtl/nvram_restore_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nvram_restore_pkg
// Purpose  : Shared types and constants for the hiscore NVRAM restore path
//            and the extract/save block that reads the same game RAM.
// Revision : 1.0  initial release
// ============================================================================
package nvram_restore_pkg;

  localparam int STATE_W = 4;

  // Restore sequencer states; CHECK1/CHECK2 are only visited in the
  // read-back verify build (NVRAM_RESTORE_VERIFY_EN).
  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 4'd0,
    S_REQ     = 4'd1,
    S_PADPRE  = 4'd2,
    S_READ    = 4'd3,
    S_WRITE   = 4'd4,
    S_CHECK1  = 4'd5,
    S_CHECK2  = 4'd6,
    S_PADPOST = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  // Idle cycles with the CPU held before and after the copy.
  localparam int DEFAULT_PAUSEPAD = 4;

  // ioctl_index used by the HPS for the hiscore dump (shared with save side).
  localparam int HISCORE_DUMPINDEX = 4;

endpackage
`default_nettype wire

// File: rtl/nvram_restore_buf.sv
`default_nettype none
// ============================================================================
// Module   : nvram_restore_buf
// Purpose  : Single-port synchronous dump buffer, 2**AW x 8, registered read.
//            Never read and written in the same cycle, so read-during-write
//            behaviour is irrelevant.
// Revision : 1.0  initial release
// ============================================================================
module nvram_restore_buf
  import nvram_restore_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [0:(1<<AW)-1];

  // Write on strobe, read data registered one cycle after the address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/nvram_restore.sv
`default_nettype none
// ============================================================================
// Module   : nvram_restore
// Purpose  : Captures the hiscore dump streamed from the HPS into a local
//            buffer, then pauses the game CPU and copies the bytes into game
//            NVRAM through the shared address/data port.
// Options  : NVRAM_RESTORE_VERIFY_EN - read back each written byte and flag
//            any mismatch on verify_error (4 cycles/byte instead of 2).
// Revision : 1.0  initial release
// ============================================================================
module nvram_restore
  import nvram_restore_pkg::*;
#(
  parameter int DUMPWIDTH = 8,
  parameter int DUMPINDEX = HISCORE_DUMPINDEX,
  parameter int PAUSEPAD  = DEFAULT_PAUSEPAD    // expected >= 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 paused,
  input  logic                 ioctl_download,
  input  logic                 ioctl_wr,
  input  logic [24:0]          ioctl_addr,
  input  logic [7:0]           ioctl_index,
  input  logic [7:0]           ioctl_dout,
  output logic [DUMPWIDTH-1:0] nvram_address,
  output logic [7:0]           nvram_data_in,
  output logic                 nvram_we,
  input  logic [7:0]           nvram_data_out,
  output logic                 pause_cpu,
  output logic                 restore_busy,
  output logic                 restore_done,
  output logic                 verify_error
);

  localparam logic [7:0]           IDX_MATCH = 8'(DUMPINDEX);
  localparam logic [24:0]          DEPTH     = 25'(1) << DUMPWIDTH;
  localparam int                   PADW      = (PAUSEPAD > 1) ? $clog2(PAUSEPAD) : 1;
  localparam logic [PADW-1:0]      PAD_LAST  = PADW'((PAUSEPAD > 0) ? PAUSEPAD - 1 : 0);
  localparam logic [PADW-1:0]      PAD_ONE   = PADW'(1);
  localparam logic [DUMPWIDTH:0]   LEN_ONE   = (DUMPWIDTH+1)'(1);
  localparam logic [DUMPWIDTH-1:0] IDX_ONE   = DUMPWIDTH'(1);

  state_t                 state, state_nxt;
  logic                   dl_match, dl_match_q, dl_start, dl_end, cap_we;
  logic [DUMPWIDTH:0]     length, cap_len;
  logic                   pending;
  logic [DUMPWIDTH-1:0]   idx, addr_q, buf_addr;
  logic [7:0]             buf_q, data_q;
  logic [PADW-1:0]        pad_cnt;
  logic                   pad_last, idx_last, copy_step, write_ok;

  // Download qualification: only the dump index, only in-window addresses.
  assign dl_match = ioctl_download && (ioctl_index == IDX_MATCH);
  assign dl_start = dl_match && !dl_match_q;
  assign dl_end   = dl_match_q && !ioctl_download;
  assign cap_we   = dl_match && ioctl_wr && (ioctl_addr < DEPTH);
  assign cap_len  = {1'b0, ioctl_addr[DUMPWIDTH-1:0]} + LEN_ONE;

  // The buffer port belongs to the capture while a dump download runs;
  // a download start aborts any copy, so the two never contend.
  assign buf_addr = dl_match ? ioctl_addr[DUMPWIDTH-1:0] : idx;

  nvram_restore_buf #(.AW(DUMPWIDTH)) u_buf (
    .clk   (clk),
    .we    (cap_we),
    .addr  (buf_addr),
    .wdata (ioctl_dout),
    .rdata (buf_q)
  );

  assign pad_last = (pad_cnt == PAD_LAST);
  assign idx_last = ({1'b0, idx} == (length - LEN_ONE));
`ifdef NVRAM_RESTORE_VERIFY_EN
  assign copy_step = (state == S_CHECK2);
`else
  assign copy_step = (state == S_WRITE);
`endif

  // Track dump length and the restore-pending flag across downloads.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_match_q <= 1'b0;
      length     <= '0;
      pending    <= 1'b0;
    end else begin
      dl_match_q <= dl_match;
      if (dl_start)
        length <= cap_we ? cap_len : '0;
      else if (cap_we && (cap_len > length))
        length <= cap_len;
      if (dl_start)
        pending <= 1'b0;
      else if (dl_end)
        pending <= (length != '0);
      else if (state == S_DONE)
        pending <= 1'b0;
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and strobe decode; a fresh dump download aborts any restore.
  always_comb begin
    state_nxt    = state;
    pause_cpu    = 1'b0;
    write_ok     = 1'b0;
    restore_done = 1'b0;
    case (state)
      S_IDLE:    if (pending && !dl_start) state_nxt = S_REQ;
      S_REQ: begin
        pause_cpu = 1'b1;
        if (paused) state_nxt = S_PADPRE;
      end
      S_PADPRE: begin
        pause_cpu = 1'b1;
        if (paused && pad_last) state_nxt = S_READ;
      end
      S_READ: begin
        pause_cpu = 1'b1;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        pause_cpu = 1'b1;
        write_ok  = 1'b1;
`ifdef NVRAM_RESTORE_VERIFY_EN
        state_nxt = S_CHECK1;
`else
        state_nxt = idx_last ? S_PADPOST : S_READ;
`endif
      end
`ifdef NVRAM_RESTORE_VERIFY_EN
      S_CHECK1: begin
        pause_cpu = 1'b1;
        state_nxt = S_CHECK2;
      end
      S_CHECK2: begin
        pause_cpu = 1'b1;
        state_nxt = idx_last ? S_PADPOST : S_READ;
      end
`endif
      S_PADPOST: begin
        pause_cpu = 1'b1;
        if (paused && pad_last) state_nxt = S_DONE;
      end
      S_DONE: begin
        restore_done = 1'b1;
        state_nxt    = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
    if (dl_start && (state != S_IDLE)) begin
      state_nxt    = S_IDLE;
      write_ok     = 1'b0;
      restore_done = 1'b0;
    end
  end

  // Copy index, pad counter and the held NVRAM address/data.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      pad_cnt <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      if ((state == S_PADPRE) || (state == S_PADPOST)) begin
        if (paused) pad_cnt <= pad_last ? '0 : pad_cnt + PAD_ONE;
      end else begin
        pad_cnt <= '0;
      end
      if (state == S_IDLE)
        idx <= '0;
      else if (copy_step && !idx_last)
        idx <= idx + IDX_ONE;
      if (state == S_READ) addr_q <= idx;
      if (write_ok)        data_q <= buf_q;
    end
  end

  assign nvram_we      = write_ok;
  assign nvram_address = addr_q;
  assign nvram_data_in = (state == S_WRITE) ? buf_q : data_q;
  assign restore_busy  = pause_cpu;

`ifdef NVRAM_RESTORE_VERIFY_EN
  logic verr_q;

  // Sticky read-back mismatch, cleared when the next restore begins.
  always_ff @(posedge clk) begin
    if (reset)
      verr_q <= 1'b0;
    else if ((state == S_IDLE) && (state_nxt == S_REQ))
      verr_q <= 1'b0;
    else if ((state == S_CHECK2) && (nvram_data_out != buf_q))
      verr_q <= 1'b1;
  end

  assign verify_error = verr_q;
`else
  logic unused_rdata;
  assign unused_rdata = ^nvram_data_out;
  assign verify_error = 1'b0;
`endif

endmodule
`default_nettype wire
